alu_issue_ctrl: RTL and testbench

Execute-stage issue controller for the MIPS datapath: the driving end of the ALU interface. It decodes each incoming instruction's opcode/funct into the ALU's 3-bit `ctrl`, `A`, `B` and `shamt`. It captures the ALU's `R`/`cout`/`ovf`/`ze` into a one-entry EX/MEM output register with valid/ready handshakes, resolves BEQ/BNE, and traps signed overflow and illegal opcodes.

---
 rtl/alu_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage issue controller driving an external ALU.
// Decodes MIPS ops, registers ALU results into EX/MEM, resolves branches, traps.

module alu_issue_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    input  logic [15:0]         imm,
    input  logic [4:0]          shamt_in,
    input  logic [4:0]          rt_idx,
    input  logic [4:0]          rd_idx,
    input  logic [31:0]         pc,
    output logic [2:0]          alu_ctrl,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [4:0]          alu_shamt,
    input  logic [31:0]         alu_r,
    input  logic                alu_cout,
    input  logic                alu_ovf,
    input  logic                alu_ze,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic [4:0]          out_dst,
    output logic                out_we,
    output logic                branch_taken,
    output logic [31:0]         branch_target,
    output logic                exc_valid,
    output logic [4:0]          exc_code,
    output logic [31:0]         exc_pc,
    input  logic                exc_ack,
    output logic [RETIRE_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    localparam logic [4:0] EXC_ILLEGAL = 5'd10;
    localparam logic [4:0] EXC_OVF     = 5'd12;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [4:0]  dec_dst;
    logic        dec_branch;
    logic        dec_bne;
    logic        dec_ovf_chk;
    logic        dec_illegal;

    logic        accept;
    logic        out_fire;
    logic        slot_free;
    logic        trap_hit;
    logic        issue_ok;
    logic        take;
    logic [31:0] target;
    logic [4:0]  trap_code;

    // The carry flag has no consumer in this stage.
    logic        unused_cout;
    assign unused_cout = alu_cout;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Combinational decode of the presented instruction into ALU controls.
    always_comb begin
        alu_ctrl    = ALU_AND;
        alu_a       = rs_val;
        alu_b       = rt_val;
        alu_shamt   = 5'd0;
        dec_dst     = 5'd0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_ovf_chk = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_dst = rd_idx;
                case (funct)
                    FN_ADD: begin
                        alu_ctrl    = ALU_ADD;
                        dec_ovf_chk = 1'b1;
                    end
                    FN_ADDU: alu_ctrl = ALU_ADDU;
                    FN_SUB: begin
                        alu_ctrl    = ALU_SUB;
                        dec_ovf_chk = 1'b1;
                    end
                    FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SLTU: alu_ctrl = ALU_SLTU;
                    FN_SLL: begin
                        alu_ctrl  = ALU_SLL;
                        alu_a     = rt_val;
                        alu_b     = 32'd0;
                        alu_shamt = shamt_in;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_ctrl    = ALU_ADD;
                alu_b       = imm_sext;
                dec_dst     = rt_idx;
                dec_ovf_chk = 1'b1;
            end
            OP_ADDIU: begin
                alu_ctrl = ALU_ADDU;
                alu_b    = imm_sext;
                dec_dst  = rt_idx;
            end
            OP_SLTI: begin
                alu_ctrl = ALU_SLT;
                alu_b    = imm_sext;
                dec_dst  = rt_idx;
            end
            OP_SLTIU: begin
                alu_ctrl = ALU_SLTU;
                alu_b    = imm_sext;
                dec_dst  = rt_idx;
            end
            OP_ANDI: begin
                alu_ctrl = ALU_AND;
                alu_b    = imm_zext;
                dec_dst  = rt_idx;
            end
            OP_ORI: begin
                alu_ctrl = ALU_OR;
                alu_b    = imm_zext;
                dec_dst  = rt_idx;
            end
            OP_BEQ: begin
                alu_ctrl   = ALU_SUB;
                dec_branch = 1'b1;
            end
            OP_BNE: begin
                alu_ctrl   = ALU_SUB;
                dec_branch = 1'b1;
                dec_bne    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign out_fire  = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == RUN) && slot_free;
    assign accept    = in_valid && in_ready;

    assign trap_hit  = accept
                     && (dec_illegal || (dec_ovf_chk && alu_ovf));
    assign issue_ok  = accept && !trap_hit;
    assign trap_code = dec_illegal ? EXC_ILLEGAL : EXC_OVF;

    assign take   = dec_branch && (dec_bne ? !alu_ze : alu_ze);
    assign target = pc + 32'd4 + {imm_sext[29:0], 2'b00};

    // Run/trap state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter TRAP on a faulting accept, leave on acknowledge.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (trap_hit) begin
                    state_next = TRAP;
                end
            end
            TRAP: begin
                if (exc_ack) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // EX/MEM entry: loads when the slot is free, holds during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= 32'd0;
            out_dst       <= 5'd0;
            out_we        <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= 32'd0;
        end else if (slot_free) begin
            out_valid <= issue_ok;
            if (issue_ok) begin
                out_result    <= alu_r;
                out_dst       <= dec_dst;
                out_we        <= !dec_branch && (dec_dst != 5'd0);
                branch_taken  <= take;
                branch_target <= target;
            end else begin
                out_we       <= 1'b0;
                branch_taken <= 1'b0;
            end
        end
    end

    // Exception record: captured on trap, cleared by acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_valid <= 1'b0;
            exc_code  <= 5'd0;
            exc_pc    <= 32'd0;
        end else if (trap_hit) begin
            exc_valid <= 1'b1;
            exc_code  <= trap_code;
            exc_pc    <= pc;
        end else if ((state == TRAP) && exc_ack) begin
            exc_valid <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (out_fire) begin
            retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with an ALU model.
// Directed vectors push hand-computed results; a monitor pops on handshake.

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [4:0]  shamt_in;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [31:0] pc;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_r;
    logic        alu_cout;
    logic        alu_ovf;
    logic        alu_ze;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dst;
    logic        out_we;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_ack;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .shamt_in(shamt_in), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .pc(pc),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_r(alu_r),
        .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_ze(alu_ze),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dst(out_dst), .out_we(out_we),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_ack(exc_ack), .retire_cnt(retire_cnt)
    );

    // Behavioural ALU attached to the controller.
    always_comb begin
        logic [32:0] sum;
        sum      = 33'd0;
        alu_r    = 32'd0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_ctrl)
            3'd0: alu_r = alu_a & alu_b;
            3'd1: alu_r = alu_a | alu_b;
            3'd2, 3'd4: begin
                sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r    = sum[31:0];
                alu_cout = sum[32];
                alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            3'd3: alu_r = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'd5: alu_r = alu_a << alu_shamt;
            3'd6: begin
                sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_r    = sum[31:0];
                alu_cout = sum[32];
                alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            default: alu_r = {31'd0, alu_a < alu_b};
        endcase
        alu_ze = (alu_r == 32'd0);
    end

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dst;
        logic        we;
        logic        br;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pushes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got result %h expected none",
                             out_result);
                end else begin
                    e = sb.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_dst", 32'(out_dst), 32'(e.dst));
                    chk("out_we", 32'(out_we), 32'(e.we));
                    chk("branch_taken", 32'(branch_taken), 32'(e.taken));
                    if (e.br) chk("branch_target", branch_target, e.tgt);
                end
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] im, input logic [4:0] sh,
                         input logic [4:0] rti, input logic [4:0] rdi,
                         input logic [31:0] p);
        opcode   = op;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        imm      = im;
        shamt_in = sh;
        rt_idx   = rti;
        rd_idx   = rdi;
        pc       = p;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] im, input logic [4:0] sh,
                         input logic [4:0] rti, input logic [4:0] rdi,
                         input logic [31:0] p, input logic [2:0] ectrl,
                         input logic [31:0] eres, input logic [4:0] edst,
                         input logic ewe, input logic ebr,
                         input logic etaken, input logic [31:0] etgt);
        logic ok;
        drive(op, fn, rs, rt, im, sh, rti, rdi, p);
        wait_accept(ok);
        if (ok) begin
            chk("alu_ctrl", 32'(alu_ctrl), 32'(ectrl));
            sb.push_back('{eres, edst, ewe, ebr, etaken, etgt});
            pushes++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_trap(input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] p, input logic [4:0] ecode,
                              input logic do_ack);
        logic ok;
        drive(op, fn, rs, rt, 16'h0000, 5'd0, 5'd1, 5'd2, p);
        wait_accept(ok);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("exc_valid", 32'(exc_valid), 32'd1);
        chk("exc_code", 32'(exc_code), 32'(ecode));
        chk("exc_pc", exc_pc, p);
        repeat (2) begin
            chk("in_ready_trap", 32'(in_ready), 32'd0);
            chk("out_valid_trap", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        if (do_ack) begin
            @(posedge clk);
            #1 exc_ack = 1'b1;
            @(negedge clk);
            chk("exc_valid_at_ack", 32'(exc_valid), 32'd1);
            @(posedge clk);
            #1 exc_ack = 1'b0;
            @(negedge clk);
            chk("exc_valid_after_ack", 32'(exc_valid), 32'd0);
            chk("in_ready_after_ack", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        chk("retire_cnt", retire_cnt, 32'(pushes));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exc_ack   = 1'b0;
        drive(6'h00, 6'h20, 32'd0, 32'd0, 16'h0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_result", out_result, 32'd0);
        @(posedge clk);
        #1;

        // op fn rs rt imm sh rt rd pc | ctrl res dst we br taken tgt
        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd0, 5'd0, 5'd3, 32'h40,
              3'd2, 32'd12, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();

        issue_trap(6'h00, 6'h20, 32'h7FFF_FFFF, 32'd1, 32'h200, 5'd12, 1'b1);

        issue(6'h00, 6'h21, 32'h7FFF_FFFF, 32'd1, 16'h0, 5'd0, 5'd0, 5'd8,
              32'h44, 3'd4, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h00, 6'h23, 32'h8000_0000, 32'd1, 16'h0, 5'd0, 5'd0, 5'd9,
              32'h48, 3'd6, 32'h7FFF_FFFF, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h04, 6'h00, 32'd9, 32'd9, 16'hFFFF, 5'd0, 5'd0, 5'd0,
              32'h100, 3'd6, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h100);
        issue(6'h05, 6'h00, 32'd9, 32'd9, 16'hFFFF, 5'd0, 5'd0, 5'd0,
              32'h100, 3'd6, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h100);
        issue(6'h00, 6'h00, 32'd0, 32'd1, 16'h0, 5'd31, 5'd0, 5'd4,
              32'h50, 3'd5, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h0D, 6'h00, 32'd0, 32'd0, 16'h8001, 5'd0, 5'd6, 5'd0,
              32'h54, 3'd1, 32'h0000_8001, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h0A, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h0000, 5'd0, 5'd7, 5'd0,
              32'h58, 3'd3, 32'd1, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h0C, 6'h00, 32'hFFFF_0F0F, 32'd0, 16'h8421, 5'd0, 5'd10, 5'd0,
              32'h5C, 3'd0, 32'h0000_0401, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFE, 5'd0, 5'd11, 5'd0,
              32'h60, 3'd2, 32'd8, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h0B, 6'h00, 32'd5, 32'd0, 16'hFFFF, 5'd0, 5'd12, 5'd0,
              32'h64, 3'd7, 32'd1, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0);
        issue(6'h00, 6'h20, 32'd1, 32'd2, 16'h0, 5'd0, 5'd0, 5'd0,
              32'h68, 3'd2, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_idle();

        issue_trap(6'h00, 6'h22, 32'h8000_0000, 32'd1, 32'h300, 5'd12, 1'b1);

        // Output stall: first entry held while the second waits.
        out_ready = 1'b0;
        issue(6'h00, 6'h25, 32'h0000_00F0, 32'h0000_000F, 16'h0, 5'd0, 5'd0,
              5'd13, 32'h70, 3'd1, 32'h0000_00FF, 5'd13, 1'b1, 1'b0, 1'b0, 32'h0);
        fork
            issue(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd0, 5'd0,
                  5'd14, 32'h74, 3'd3, 32'd1, 5'd14, 1'b1, 1'b0, 1'b0, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_result", out_result, 32'h0000_00FF);
                    chk("stall_dst", 32'(out_dst), 32'd13);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();

        // Illegal opcode, then reset while still trapped.
        issue_trap(6'h3F, 6'h00, 32'd0, 32'd0, 32'h400, 5'd10, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pushes = 0;
        @(negedge clk);
        chk("trst_in_ready", 32'(in_ready), 32'd1);
        chk("trst_exc_valid", 32'(exc_valid), 32'd0);
        chk("trst_exc_code", 32'(exc_code), 32'd0);
        chk("trst_exc_pc", exc_pc, 32'd0);
        chk("trst_out_valid", 32'(out_valid), 32'd0);
        chk("trst_retire", retire_cnt, 32'd0);
        chk("trst_target", branch_target, 32'd0);
        @(posedge clk);
        #1;
        issue(6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 5'd0, 5'd0, 5'd2, 32'h80,
              3'd2, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
